// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes and the layout of a
// buffered result entry {op[1:0], carry, zero, res[3:0]}.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    localparam int ENTRY_W   = 8;
    localparam int RES_W     = 4;
    localparam int OP_W      = 2;
    localparam int RES_LSB   = 0;
    localparam int ZERO_BIT  = 4;
    localparam int CARRY_BIT = 5;
    localparam int OP_LSB    = 6;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [OP_W-1:0]  op,
        input logic             carry,
        input logic             zero,
        input logic [RES_W-1:0] res
    );
        logic [ENTRY_W-1:0] e;
        e                     = '0;
        e[RES_LSB +: RES_W]   = res;
        e[ZERO_BIT]           = zero;
        e[CARRY_BIT]          = carry;
        e[OP_LSB +: OP_W]     = op;
        return e;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bus of the ALU result stage: raw ALU results on the upstream
// side, the buffered head entry on the downstream side.
interface alu_result_stage_if;

    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] yadd;
    logic [3:0] ysub;
    logic [3:0] ynand;
    logic [3:0] ynor;
    logic       cout_add;
    logic       cout_sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_carry;
    logic       out_zero;
    logic [1:0] out_op;

    modport master (
        output in_valid, op, yadd, ysub, ynand, ynor, cout_add, cout_sub, out_ready,
        input  in_ready, out_valid, out_res, out_carry, out_zero, out_op
    );

    modport slave (
        input  in_valid, op, yadd, ysub, ynand, ynor, cout_add, cout_sub, out_ready,
        output in_ready, out_valid, out_res, out_carry, out_zero, out_op
    );

endinterface

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty come straight
// from the count so no handshake output has a combinational input path.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Guard both ports so impossible handshakes leave state untouched.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; readers ignore it while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 4-bit ALU: picks the result for the
// opcode, derives carry/zero, buffers it, and tracks op count and sticky carry.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_stage_if.slave bus,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  op_count,
    output logic              carry_sticky
);

    logic [RES_W-1:0]   sel_res;
    logic               sel_carry;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Pick the ALU output and its carry/borrow for the requested operation.
    always_comb begin
        sel_res   = bus.yadd;
        sel_carry = bus.cout_add;
        case (bus.op)
            OP_ADD: begin
                sel_res   = bus.yadd;
                sel_carry = bus.cout_add;
            end
            OP_SUB: begin
                sel_res   = bus.ysub;
                sel_carry = bus.cout_sub;
            end
            OP_NAND: begin
                sel_res   = bus.ynand;
                sel_carry = 1'b0;
            end
            OP_NOR: begin
                sel_res   = bus.ynor;
                sel_carry = 1'b0;
            end
            default: begin
                sel_res   = bus.yadd;
                sel_carry = bus.cout_add;
            end
        endcase
    end

    assign wr_entry     = pack_entry(bus.op, sel_carry, (sel_res == '0), sel_res);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = !empty && bus.out_ready;

    alu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Head fields are zeroed while nothing valid is presented.
    assign bus.out_valid = !empty;
    assign bus.out_res   = empty ? '0   : head[RES_LSB +: RES_W];
    assign bus.out_zero  = empty ? 1'b0 : head[ZERO_BIT];
    assign bus.out_carry = empty ? 1'b0 : head[CARRY_BIT];
    assign bus.out_op    = empty ? '0   : head[OP_LSB +: OP_W];

    // Saturating count of accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (push && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    // Sticky carry; a carrying push in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_sticky <= 1'b0;
        end else if (push && sel_carry) begin
            carry_sticky <= 1'b1;
        end else if (clr_sticky) begin
            carry_sticky <= 1'b0;
        end
    end

endmodule
